// File: rtl/fixed_point_sign_sequencer.sv
// Issue/collect sequencer wrapped around a fixed-point change-sign stage.
// It accepts one (value, target sign) request and forwards it to the stage.
// It then waits for the result and presents it downstream under ready/valid.
// Only one request is in flight at a time. The stage's fast (sign already
// matches) and slow (adder) paths therefore can never reorder results.
// A WAIT that outlives TIMEOUT_CYCLES drops the request and raises a sticky flag.
module fixed_point_sign_sequencer #(
   parameter int WIDTH          = 8,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                    CLK,
   input  logic                    RSTN,
   input  logic signed [WIDTH-1:0] S_VALUE,
   input  logic                    S_TARGET_SIGN,
   input  logic                    S_VALID,
   output logic                    S_READY,
   output logic signed [WIDTH-1:0] CS_VALUE,
   output logic                    CS_TARGET_SIGN,
   output logic                    CS_VALID,
   input  logic signed [WIDTH-1:0] CS_VALUE_OUT,
   input  logic                    CS_VALID_OUT,
   input  logic                    CS_OVERFLOW,
   output logic signed [WIDTH-1:0] M_VALUE,
   output logic                    M_OVERFLOW,
   output logic                    M_VALID,
   input  logic                    M_READY,
   output logic                    TIMEOUT_ERR,
   input  logic                    ERR_CLR
);

   localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_HOLD
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] wait_cnt;
   logic             timeout_hit;

   // A response arriving on the last allowed WAIT cycle beats the timeout
   assign timeout_hit = (state == ST_WAIT) && !CS_VALID_OUT && (wait_cnt == CNT_LAST);

   // Request/response FSM with registered handshake, data and error outputs
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state          <= ST_IDLE;
         wait_cnt       <= '0;
         S_READY        <= 1'b0;
         CS_VALUE       <= '0;
         CS_TARGET_SIGN <= 1'b0;
         CS_VALID       <= 1'b0;
         M_VALUE        <= '0;
         M_OVERFLOW     <= 1'b0;
         M_VALID        <= 1'b0;
         TIMEOUT_ERR    <= 1'b0;
      end else begin
         // Setting the error flag takes priority over a simultaneous clear
         if (timeout_hit) begin
            TIMEOUT_ERR <= 1'b1;
         end else if (ERR_CLR) begin
            TIMEOUT_ERR <= 1'b0;
         end

         case (state)
            ST_IDLE: begin
               if (S_VALID && S_READY) begin
                  CS_VALUE       <= S_VALUE;
                  CS_TARGET_SIGN <= S_TARGET_SIGN;
                  CS_VALID       <= 1'b1;
                  S_READY        <= 1'b0;
                  state          <= ST_ISSUE;
               end else begin
                  S_READY <= 1'b1;
               end
            end

            // CS_VALID is high for exactly the single ISSUE cycle
            ST_ISSUE: begin
               CS_VALID <= 1'b0;
               wait_cnt <= '0;
               state    <= ST_WAIT;
            end

            ST_WAIT: begin
               if (CS_VALID_OUT) begin
                  M_VALUE    <= CS_VALUE_OUT;
                  M_OVERFLOW <= CS_OVERFLOW;
                  M_VALID    <= 1'b1;
                  state      <= ST_HOLD;
               end else if (timeout_hit) begin
                  S_READY <= 1'b1;
                  state   <= ST_IDLE;
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
            end

            // Result held stable until downstream takes it
            ST_HOLD: begin
               if (M_READY) begin
                  M_VALID <= 1'b0;
                  S_READY <= 1'b1;
                  state   <= ST_IDLE;
               end
            end

            default: begin
               CS_VALID <= 1'b0;
               M_VALID  <= 1'b0;
               S_READY  <= 1'b0;
               state    <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
